screen_generator: RTL and testbench

SCREEN_GENERATOR -- requirements
Module: screen_generator

---
 rtl/screen_generator_pkg.sv | 18 +
 rtl/sync_axis_counter.sv | 42 ++++
 rtl/screen_generator.sv | 98 +++++++++
 tb/tb_screen_generator.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/screen_generator_pkg.sv
// Shared types for the screen generator: axis state encoding, counter widths
// and the 24-bit {R,G,B} pixel type.
package screen_generator_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } axis_state_t;

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis (horizontal or vertical): position counter with wrap at the
// axis total, plus decode of ACTIVE / FP / SYNC / BP from the count.
module sync_axis_counter
  import screen_generator_pkg::*;
#(
  parameter int           W      = 11,
  parameter logic [W-1:0] ACTIVE = '0,
  parameter logic [W-1:0] FP     = '0,
  parameter logic [W-1:0] SYNC   = '0,
  parameter logic [W-1:0] BP     = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         enable,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output axis_state_t  state
);

  localparam logic [W-1:0] FP_END   = ACTIVE + FP;
  localparam logic [W-1:0] SYNC_END = FP_END + SYNC;
  localparam logic [W-1:0] TOTAL    = SYNC_END + BP;
  localparam logic [W-1:0] LAST     = TOTAL - W'(1);

  assign wrap = step && (cnt == LAST);

  // Deasserting enable parks the axis at 0 so the next run starts a fresh frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (step)    cnt <= wrap ? '0 : cnt + W'(1);
  end

  always_comb begin
    state = ST_BP;
    if (cnt < ACTIVE)        state = ST_ACTIVE;
    else if (cnt < FP_END)   state = ST_FP;
    else if (cnt < SYNC_END) state = ST_SYNC;
  end

endmodule

// File: rtl/screen_generator.sv
// Video timing generator with registered sync/vde/pixel outputs (latency 1).
// Define SCREEN_GENERATOR_MARKER_EN to enable the two single-pixel markers.
module screen_generator
  import screen_generator_pkg::*;
#(
  parameter logic [H_CNT_W-1:0] H_ACTIVE = 11'd1280,
  parameter logic [H_CNT_W-1:0] H_FP     = 11'd110,
  parameter logic [H_CNT_W-1:0] H_SYNC   = 11'd40,
  parameter logic [H_CNT_W-1:0] H_BP     = 11'd220,
  parameter logic [V_CNT_W-1:0] V_ACTIVE = 10'd720,
  parameter logic [V_CNT_W-1:0] V_FP     = 10'd5,
  parameter logic [V_CNT_W-1:0] V_SYNC   = 10'd5,
  parameter logic [V_CNT_W-1:0] V_BP     = 10'd20,
  parameter logic               SYNC_POL = 1'b1,
  parameter pixel_t             BG_COLOR = 24'h00_00_00,
  parameter logic [H_CNT_W-1:0] xPos1    = 11'd83,
  parameter logic [V_CNT_W-1:0] yPos1    = 10'd605,
  parameter pixel_t             pixel1   = 24'h38_73_00,
  parameter logic [H_CNT_W-1:0] xPos2    = 11'd366,
  parameter logic [V_CNT_W-1:0] yPos2    = 10'd605,
  parameter pixel_t             pixel2   = 24'hD5_D5_00
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          vde,
  output logic [23:0]   rgb_pixel,
  output logic          frame_start
);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_wrap, v_wrap;
  axis_state_t        h_state, v_state;
  logic               in_active;
  logic               origin;
  pixel_t             active_pix;

  sync_axis_counter #(
    .W(H_CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .step(1'b1),
    .cnt(h_cnt), .wrap(h_wrap), .state(h_state)
  );

  sync_axis_counter #(
    .W(V_CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .step(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .state(v_state)
  );

  assign in_active = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);

  // Counters sit at (0,0) exactly after a frame wrap or while parked, so this
  // flag replaces a full-width compare of both counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       origin <= 1'b1;
    else if (!enable) origin <= 1'b1;
    else              origin <= v_wrap;
  end

`ifdef SCREEN_GENERATOR_MARKER_EN
  // Marker 1 is evaluated last so it wins when both coordinates coincide.
  always_comb begin
    active_pix = BG_COLOR;
    if (h_cnt == xPos2 && v_cnt == yPos2) active_pix = pixel2;
    if (h_cnt == xPos1 && v_cnt == yPos1) active_pix = pixel1;
  end
`else
  assign active_pix = BG_COLOR;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      vde         <= 1'b0;
      rgb_pixel   <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      vde         <= 1'b0;
      rgb_pixel   <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vde         <= in_active;
      rgb_pixel   <= in_active ? active_pix : '0;
      frame_start <= origin;
    end
  end

endmodule

// File: tb/tb_screen_generator.sv
// Directed bench for screen_generator on a 14x7 timing: two instances, one
// with active-high syncs and a (3,2) marker, one active-low with both markers at (1,1).
module tb_screen_generator;

  localparam logic [23:0] BG_A = 24'h112233;
  localparam logic [23:0] BG_B = 24'h445566;
  localparam logic [23:0] PX_A = 24'hAABBCC;
  localparam logic [23:0] PX_B = 24'h0A0B0C;
`ifdef SCREEN_GENERATOR_MARKER_EN
  localparam logic [23:0] MK_A   = PX_A;
  localparam logic [23:0] MK_B   = PX_B;
  localparam int          EXP_MK = 1;
  localparam int          EXP_BG = 31;
`else
  localparam logic [23:0] MK_A   = BG_A;
  localparam logic [23:0] MK_B   = BG_B;
  localparam int          EXP_MK = 0;
  localparam int          EXP_BG = 32;
`endif

  logic        CLK = 1'b0;
  logic        RST_N, enable;
  logic        hsync_a, vsync_a, vde_a, fs_a;
  logic        hsync_b, vsync_b, vde_b, fs_b;
  logic [23:0] rgb_a, rgb_b;

  int total = 0;
  int bad   = 0;
  int n_mk, n_bg, n_hs, n_vs;

  always #5 CLK = ~CLK;

  screen_generator #(
    .H_ACTIVE(11'd8), .H_FP(11'd2), .H_SYNC(11'd2), .H_BP(11'd2),
    .V_ACTIVE(10'd4), .V_FP(10'd1), .V_SYNC(10'd1), .V_BP(10'd1),
    .SYNC_POL(1'b1), .BG_COLOR(BG_A),
    .xPos1(11'd3), .yPos1(10'd2), .pixel1(PX_A),
    .xPos2(11'd9), .yPos2(10'd2), .pixel2(24'hDDEEFF)
  ) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .hsync(hsync_a), .vsync(vsync_a), .vde(vde_a),
    .rgb_pixel(rgb_a), .frame_start(fs_a)
  );

  screen_generator #(
    .H_ACTIVE(11'd8), .H_FP(11'd2), .H_SYNC(11'd2), .H_BP(11'd2),
    .V_ACTIVE(10'd4), .V_FP(10'd1), .V_SYNC(10'd1), .V_BP(10'd1),
    .SYNC_POL(1'b0), .BG_COLOR(BG_B),
    .xPos1(11'd1), .yPos1(10'd1), .pixel1(PX_B),
    .xPos2(11'd1), .yPos2(10'd1), .pixel2(24'h0D0E0F)
  ) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .hsync(hsync_b), .vsync(vsync_b), .vde(vde_b),
    .rgb_pixel(rgb_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ":hsync_a"}, 32'(hsync_a), 32'd0);
    chk({tag, ":vsync_a"}, 32'(vsync_a), 32'd0);
    chk({tag, ":vde_a"},   32'(vde_a),   32'd0);
    chk({tag, ":rgb_a"},   32'(rgb_a),   32'd0);
    chk({tag, ":fs_a"},    32'(fs_a),    32'd0);
    chk({tag, ":hsync_b"}, 32'(hsync_b), 32'd1);
    chk({tag, ":vsync_b"}, 32'(vsync_b), 32'd1);
    chk({tag, ":vde_b"},   32'(vde_b),   32'd0);
    chk({tag, ":rgb_b"},   32'(rgb_b),   32'd0);
    chk({tag, ":fs_b"},    32'(fs_b),    32'd0);
  endtask

  // idx = position within the 98-cycle frame whose outputs are now visible
  task automatic check_pos(input int idx);
    int          h, v;
    logic        hs_e, vs_e, act;
    logic [23:0] ea, eb;
    h    = idx % 14;
    v    = idx / 14;
    hs_e = (h >= 10) && (h < 12);
    vs_e = (v == 5);
    act  = (h < 8) && (v < 4);
    ea   = !act ? 24'h0 : (h == 3 && v == 2) ? MK_A : BG_A;
    eb   = !act ? 24'h0 : (h == 1 && v == 1) ? MK_B : BG_B;
    chk($sformatf("hsync_a@%0d", idx), 32'(hsync_a), 32'(hs_e));
    chk($sformatf("vsync_a@%0d", idx), 32'(vsync_a), 32'(vs_e));
    chk($sformatf("vde_a@%0d", idx),   32'(vde_a),   32'(act));
    chk($sformatf("rgb_a@%0d", idx),   32'(rgb_a),   32'(ea));
    chk($sformatf("fs_a@%0d", idx),    32'(fs_a),    32'(idx == 0));
    chk($sformatf("hsync_b@%0d", idx), 32'(hsync_b), 32'(!hs_e));
    chk($sformatf("vsync_b@%0d", idx), 32'(vsync_b), 32'(!vs_e));
    chk($sformatf("rgb_b@%0d", idx),   32'(rgb_b),   32'(eb));
    chk($sformatf("fs_b@%0d", idx),    32'(fs_b),    32'(idx == 0));
    if (idx == 0) begin
      n_mk = 0; n_bg = 0; n_hs = 0; n_vs = 0;
    end
    if (vde_a && rgb_a == PX_A) n_mk++;
    if (vde_a && rgb_a == BG_A) n_bg++;
    if (hsync_a) n_hs++;
    if (vsync_a) n_vs++;
    if (idx == 97) begin
      chk("frame_marker_cnt", 32'(n_mk), 32'(EXP_MK));
      chk("frame_bg_cnt",     32'(n_bg), 32'(EXP_BG));
      chk("frame_hsync_cyc",  32'(n_hs), 32'd14);
      chk("frame_vsync_cyc",  32'(n_vs), 32'd14);
    end
  endtask

  task automatic check_span(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      check_pos(i % 98);
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_idle("reset");

    // two full frames from reset release
    RST_N  = 1'b1;
    enable = 1'b1;
    check_span(196);

    // counters now at h=5,v=2: drop enable, then restart a full frame
    check_span(33);
    enable = 1'b0;
    @(posedge CLK);
    #1;
    check_idle("en_off");
    @(posedge CLK);
    #1;
    check_idle("en_off2");
    enable = 1'b1;
    check_span(98);

    // asynchronous reset mid-line, well away from any clock edge
    check_span(2);
    #2;
    RST_N = 1'b0;
    #1;
    check_idle("rst_async");
    #2;
    RST_N = 1'b1;
    check_span(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
